// File: rtl/stack_pkg.sv
// Shared constants for the operand stack and its command sequencer:
// stack op / status encodings, value type tags, error codes and FSM states.
package stack_pkg;

  localparam logic [1:0] OpNone    = 2'd0;
  localparam logic [1:0] OpPush    = 2'd1;
  localparam logic [1:0] OpPop     = 2'd2;
  localparam logic [1:0] OpReplace = 2'd3;

  localparam logic [1:0] StatOk        = 2'd0;
  localparam logic [1:0] StatEmpty     = 2'd1;
  localparam logic [1:0] StatUnderflow = 2'd2;
  localparam logic [1:0] StatOverflow  = 2'd3;

  localparam logic [1:0] TagI32 = 2'd0;
  localparam logic [1:0] TagI64 = 2'd1;
  localparam logic [1:0] TagF32 = 2'd2;
  localparam logic [1:0] TagF64 = 2'd3;

  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrUnderflow = 2'd1;
  localparam logic [1:0] ErrOverflow  = 2'd2;
  localparam logic [1:0] ErrType      = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StPopw,
    StDeliver,
    StPush,
    StPushw,
    StError
  } seq_state_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// Command/operand/result bundle between the execute stage (master) and the
// stack sequencer (slave).
interface stack_sequencer_if #(
  parameter int unsigned WIDTH = 66
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_pops;
  logic             req_tcheck;
  logic             req_push;
  logic             opnd_valid;
  logic [WIDTH-1:0] opnd0;
  logic [WIDTH-1:0] opnd1;
  logic [WIDTH-1:0] opnd2;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             done;
  logic [1:0]       err;

  modport master (
    output req_valid, req_pops, req_tcheck, req_push, res_valid, res_data,
    input  req_ready, opnd_valid, opnd0, opnd1, opnd2, done, err
  );

  modport slave (
    input  req_valid, req_pops, req_tcheck, req_push, res_valid, res_data,
    output req_ready, opnd_valid, opnd0, opnd1, opnd2, done, err
  );
endinterface

// File: rtl/stack.sv
// Operand stack: one registered op per cycle, combinational top-of-stack and
// status. A failed op leaves a fault status until the next successful op.
module stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] tos,
  output logic [1:0]       status
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d, top;
  logic [1:0]       fault_q, fault_d;
  logic             full, empty;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign top   = cnt_q - CW'(1);

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (op)
      OpPush: begin
        if (full) begin
          fault_d = StatOverflow;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          fault_d = StatOk;
        end
      end
      OpPop: begin
        if (empty) begin
          fault_d = StatUnderflow;
        end else begin
          cnt_d   = top;
          fault_d = StatOk;
        end
      end
      OpReplace: fault_d = empty ? StatUnderflow : StatOk;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      fault_q <= StatOk;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (op == OpPush && !full) begin
      mem_q[cnt_q[AW-1:0]] <= data;
    end else if (op == OpReplace && !empty) begin
      mem_q[top[AW-1:0]] <= data;
    end
  end

  assign tos    = empty ? '0 : mem_q[top[AW-1:0]];
  assign status = (fault_q != StatOk) ? fault_q : (empty ? StatEmpty : StatOk);

endmodule

// File: rtl/stack_sequencer.sv
// Runs one pop/type-check/deliver/push command against the operand stack,
// issuing at most one registered stack op every other cycle.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 66
) (
  input  logic             clk,
  input  logic             reset,
  stack_sequencer_if.slave cmd,
  output logic [1:0]       stk_op,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_tos,
  input  logic [1:0]       stk_status
);
  seq_state_e       state_q, state_d;
  logic [1:0]       pops_q, pops_d;
  logic [1:0]       k_q, k_d, k_inc;
  logic             tcheck_q, tcheck_d;
  logic             push_q, push_d;
  logic [WIDTH-1:0] opnd_q [3];
  logic [WIDTH-1:0] opnd_d [3];
  logic             opnd_valid_q, opnd_valid_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [1:0]       stk_op_q, stk_op_d;
  logic [WIDTH-1:0] stk_data_q, stk_data_d;
  logic             tag_mismatch;

  assign k_inc        = k_q + 2'd1;
  assign tag_mismatch = (opnd_q[1][WIDTH-1 -: 2] != opnd_q[2][WIDTH-1 -: 2]);

  always_comb begin
    state_d      = state_q;
    pops_d       = pops_q;
    k_d          = k_q;
    tcheck_d     = tcheck_q;
    push_d       = push_q;
    opnd_d       = opnd_q;
    opnd_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    stk_op_d     = OpNone;
    stk_data_d   = stk_data_q;

    case (state_q)
      StIdle: begin
        if (cmd.req_valid) begin
          pops_d   = cmd.req_pops;
          tcheck_d = cmd.req_tcheck;
          push_d   = cmd.req_push;
          k_d      = 2'd0;
          if (cmd.req_pops != 2'd0) begin
            state_d = StPop;
          end else if (cmd.req_push) begin
            state_d = StDeliver;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StPop: begin
        if (stk_status == StatEmpty) begin
          err_d   = ErrUnderflow;
          state_d = StError;
        end else begin
          case (k_q)
            2'd0:    opnd_d[0] = stk_tos;
            2'd1:    opnd_d[1] = stk_tos;
            default: opnd_d[2] = stk_tos;
          endcase
          stk_op_d = OpPop;
          state_d  = StPopw;
        end
      end
      StPopw: begin
        if (stk_status > StatEmpty) begin
          err_d   = ErrUnderflow;
          state_d = StError;
        end else begin
          k_d     = k_inc;
          state_d = (k_inc < pops_q) ? StPop : StDeliver;
        end
      end
      StDeliver: begin
        // opnd_valid_q low marks the first DELIVER cycle, where the tag check runs.
        if (!opnd_valid_q) begin
          if (tcheck_q && tag_mismatch) begin
            err_d   = ErrType;
            state_d = StError;
          end else begin
            opnd_valid_d = 1'b1;
            if (!push_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end else if (cmd.res_valid) begin
          stk_op_d   = OpPush;
          stk_data_d = cmd.res_data;
          state_d    = StPush;
        end else begin
          opnd_valid_d = 1'b1;
        end
      end
      StPush: state_d = StPushw;
      StPushw: begin
        if (stk_status == StatOverflow) begin
          err_d   = ErrOverflow;
          state_d = StError;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StError: ;
      default: state_d = StError;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pops_q       <= 2'd0;
      k_q          <= 2'd0;
      tcheck_q     <= 1'b0;
      push_q       <= 1'b0;
      opnd_q[0]    <= '0;
      opnd_q[1]    <= '0;
      opnd_q[2]    <= '0;
      opnd_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ErrNone;
      stk_op_q     <= OpNone;
      stk_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      pops_q       <= pops_d;
      k_q          <= k_d;
      tcheck_q     <= tcheck_d;
      push_q       <= push_d;
      opnd_q       <= opnd_d;
      opnd_valid_q <= opnd_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      stk_op_q     <= stk_op_d;
      stk_data_q   <= stk_data_d;
    end
  end

  assign cmd.req_ready  = (state_q == StIdle);
  assign cmd.opnd_valid = opnd_valid_q;
  assign cmd.opnd0      = opnd_q[0];
  assign cmd.opnd1      = opnd_q[1];
  assign cmd.opnd2      = opnd_q[2];
  assign cmd.done       = done_q;
  assign cmd.err        = err_q;
  assign stk_op         = stk_op_q;
  assign stk_data       = stk_data_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer driving a real depth-8 stack; a reference
// stack model feeds a queue of expected operand sets checked on opnd_valid.
module tb_stack_sequencer;
  import stack_pkg::*;

  localparam int unsigned W = 66;

  typedef struct {
    int           n;
    logic [W-1:0] v [3];
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stk_rst_n = 1'b0;
  logic [1:0]   stk_op;
  logic [W-1:0] stk_data;
  logic [W-1:0] stk_tos;
  logic [1:0]   stk_status;

  int checks = 0;
  int passes = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  int b2b_viol = 0;
  logic [1:0] prev_op = OpNone;

  logic [W-1:0] model [$];
  exp_t         sb [$];

  stack_sequencer_if #(.WIDTH(W)) bus ();

  stack_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .cmd        (bus),
    .stk_op     (stk_op),
    .stk_data   (stk_data),
    .stk_tos    (stk_tos),
    .stk_status (stk_status)
  );

  stack #(.WIDTH(W), .DEPTH(8)) u_stk (
    .clk    (clk),
    .reset  (stk_rst_n),
    .op     (stk_op),
    .data   (stk_data),
    .tos    (stk_tos),
    .status (stk_status)
  );

  always #5 clk = ~clk;

  // Stack-op monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (stk_op == OpPop) pop_cnt <= pop_cnt + 1;
    if (stk_op == OpPush) push_cnt <= push_cnt + 1;
    if (stk_op != OpNone && prev_op != OpNone) b2b_viol <= b2b_viol + 1;
    prev_op <= stk_op;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [1:0] tag, input logic [63:0] val);
    return {tag, val};
  endfunction

  function automatic logic [W-1:0] opnd_at(input int i);
    if (i == 0) return bus.opnd0;
    if (i == 1) return bus.opnd1;
    return bus.opnd2;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks += 1;
    assert (obs === exp) passes += 1;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stk_rst_n      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_pops   = 2'd0;
    bus.req_tcheck = 1'b0;
    bus.req_push   = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    stk_rst_n = 1'b1;
    model.delete();
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  // Offers a command until accepted; returns at #1 after the accept edge.
  task automatic issue(input logic [1:0] pops, input logic tc, input logic pu);
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_pops   = pops;
    bus.req_tcheck = tc;
    bus.req_push   = pu;
    for (int i = 0; i < 50 && !bus.req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!bus.req_ready) chk("accept_timeout", W'(bus.req_ready), W'(1));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e.n = int'(pops);
    for (int i = 0; i < e.n; i++) e.v[i] = (model.size() > 0) ? model.pop_back() : 'x;
    if (pops != 2'd0 || pu) sb.push_back(e);
  endtask

  // Counts cycles from the current one until opnd_valid, then scores operands.
  task automatic wait_opnd(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!bus.opnd_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.opnd_valid) begin
      chk({tag, "_opnd_timeout"}, W'(bus.opnd_valid), W'(1));
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < e.n; i++) chk($sformatf("%s_opnd%0d", tag, i), opnd_at(i), e.v[i]);
    end
  endtask

  task automatic give_res(input string tag, input logic [W-1:0] v, output int lat);
    bus.res_valid = 1'b1;
    bus.res_data  = v;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) chk({tag, "_done_timeout"}, W'(bus.done), W'(1));
    else model.push_back(v);
  endtask

  task automatic push_val(input logic [W-1:0] v);
    int lat;
    issue(2'd0, 1'b0, 1'b1);
    wait_opnd("prepush", lat);
    give_res("prepush", v, lat);
  endtask

  initial begin
    int lat;
    int p0;
    int q0;
    bus.req_valid  = 1'b0;
    bus.req_pops   = 2'd0;
    bus.req_tcheck = 1'b0;
    bus.req_push   = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_data   = '0;

    // Reset values while reset is held.
    #3;
    chk("rst_req_ready", W'(bus.req_ready), W'(1));
    chk("rst_opnd_valid", W'(bus.opnd_valid), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_err", W'(bus.err), W'(ErrNone));
    chk("rst_stk_op", W'(stk_op), W'(OpNone));
    chk("rst_stk_data", stk_data, '0);
    chk("rst_opnd0", bus.opnd0, '0);
    do_reset();

    // Empty command: done pulses the cycle after accept.
    issue(2'd0, 1'b0, 1'b0);
    chk("nop_done", W'(bus.done), W'(1));

    // Select path.
    push_val(mk(TagI32, 5));
    push_val(mk(TagI32, 7));
    push_val(mk(TagI32, 1));
    issue(2'd3, 1'b1, 1'b1);
    wait_opnd("sel", lat);
    chk("sel_opnd_latency", W'(lat), W'(7));
    give_res("sel", mk(TagI32, 7), lat);
    chk("sel_done_latency", W'(lat), W'(2));
    chk("sel_stack_tos", stk_tos, model[model.size()-1]);
    chk("sel_stack_count", W'(u_stk.cnt_q), W'(model.size()));

    // Pop without push: single-cycle opnd_valid alongside done.
    issue(2'd1, 1'b0, 1'b0);
    wait_opnd("pop1", lat);
    chk("pop1_latency", W'(lat), W'(3));
    chk("pop1_done", W'(bus.done), W'(1));
    @(posedge clk);
    #1;
    chk("pop1_valid_drop", W'(bus.opnd_valid), W'(0));

    // Type mismatch.
    do_reset();
    push_val(mk(TagI32, 1));
    push_val(mk(TagI64, 2));
    push_val(mk(TagI32, 1));
    q0 = push_cnt;
    issue(2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 20 && bus.err == ErrNone; i++) begin
      @(posedge clk);
      #1;
    end
    chk("tmis_err", W'(bus.err), W'(ErrType));
    bus.res_valid = 1'b1;
    bus.res_data  = mk(TagI32, 9);
    repeat (4) @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    chk("tmis_no_push", W'(push_cnt - q0), W'(0));
    chk("tmis_ready", W'(bus.req_ready), W'(0));
    chk("tmis_opnd_valid", W'(bus.opnd_valid), W'(0));

    // Underflow on an empty stack.
    do_reset();
    p0 = pop_cnt;
    issue(2'd1, 1'b0, 1'b0);
    chk("udf_err_early", W'(bus.err), W'(ErrNone));
    @(posedge clk);
    #1;
    chk("udf_err", W'(bus.err), W'(ErrUnderflow));
    repeat (3) @(posedge clk);
    #1;
    chk("udf_no_pop", W'(pop_cnt - p0), W'(0));
    chk("udf_ready", W'(bus.req_ready), W'(0));

    // Overflow on a full stack.
    do_reset();
    for (int i = 0; i < 8; i++) push_val(mk(TagI64, 64'(100 + i)));
    issue(2'd0, 1'b0, 1'b1);
    wait_opnd("ovf", lat);
    bus.res_valid = 1'b1;
    bus.res_data  = mk(TagI64, 999);
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_err", W'(bus.err), W'(ErrOverflow));
    chk("ovf_no_done", W'(bus.done), W'(0));

    // Reset in the second POPW of a three-pop command.
    do_reset();
    push_val(mk(TagI32, 11));
    push_val(mk(TagI32, 12));
    push_val(mk(TagI32, 13));
    p0 = pop_cnt;
    issue(2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 40 && (pop_cnt - p0) < 2; i++) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_req_ready", W'(bus.req_ready), W'(1));
    chk("mid_opnd_valid", W'(bus.opnd_valid), W'(0));
    chk("mid_done", W'(bus.done), W'(0));
    chk("mid_err", W'(bus.err), W'(ErrNone));
    chk("mid_stk_op", W'(stk_op), W'(OpNone));
    chk("mid_stk_data", stk_data, '0);
    chk("mid_opnd0", bus.opnd0, '0);
    chk("mid_opnd1", bus.opnd1, '0);
    chk("mid_opnd2", bus.opnd2, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_pop_strobes", W'(pop_cnt - p0), W'(2));

    // Back-to-back pop1/push1 commands.
    do_reset();
    push_val(mk(TagF32, 21));
    push_val(mk(TagF32, 22));
    p0 = b2b_viol;
    issue(2'd1, 1'b0, 1'b1);
    wait_opnd("b2b1", lat);
    bus.req_valid  = 1'b1;
    bus.req_pops   = 2'd1;
    bus.req_tcheck = 1'b0;
    bus.req_push   = 1'b1;
    give_res("b2b1", mk(TagF64, 31), lat);
    chk("b2b_ready_on_done", W'(bus.req_ready), W'(1));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("b2b_accepted", W'(bus.req_ready), W'(0));
    begin
      exp_t e;
      e.n    = 1;
      e.v[0] = model.pop_back();
      sb.push_back(e);
    end
    wait_opnd("b2b2", lat);
    chk("b2b2_latency", W'(lat), W'(3));
    give_res("b2b2", mk(TagF64, 32), lat);
    @(posedge clk);
    #1;
    chk("b2b_stack_tos", stk_tos, model[model.size()-1]);
    chk("b2b_no_consecutive_ops", W'(b2b_viol - p0), W'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
